// File: rtl/restador_serial.sv
// ---------------------------------------------------------------------------
// restador_serial
//   Bit-serial ANCHO-bit subtractor computing A - B, one bit pair per clock,
//   LSB first, through a single Restador_Completo full-subtractor cell.
//   The borrow is carried between cycles in a flip-flop and the result word
//   is assembled in a right-shifting register. One subtraction takes
//   ANCHO+2 cycles including the accept edge and the FIN cycle.
//
// Optional feature macro: RESTADOR_SERIAL_DESBORDE_EN
//   When defined, adds the Desborde output (two's-complement overflow of the
//   subtraction), loaded together with Resta.
//
// Parameters
//   ANCHO           operand/result width, ANCHO >= 2
//
// Ports
//   Reloj           in   clock, rising edge
//   Reset           in   asynchronous, active-high reset
//   Inicio          in   start request, only honoured in REPOSO
//   A, B            in   operands, captured on the accepted-Inicio edge
//   Ocupado         out  high while the bits are being computed (RESTANDO)
//   Listo           out  one-cycle pulse, Resta/PrestamoSalida just updated
//   Resta           out  registered A - B mod 2^ANCHO, held until next result
//   PrestamoSalida  out  final borrow (A < B unsigned)
//   Desborde        out  signed overflow (only with RESTADOR_SERIAL_DESBORDE_EN)
// ---------------------------------------------------------------------------

// One-bit full subtractor: R = X - Y - CarrieNEntrada, CarrieNSalida = borrow.
module Restador_Completo (
   input  logic X,
   input  logic Y,
   input  logic CarrieNEntrada,
   output logic R,
   output logic CarrieNSalida
);

   assign R             = X ^ Y ^ CarrieNEntrada;
   assign CarrieNSalida = (~X & Y) | (~(X ^ Y) & CarrieNEntrada);

endmodule

// State table
//   state    | meaning
//   REPOSO   | idle, waiting for Inicio; outputs hold last result
//   RESTANDO | one operand bit pair consumed per edge, LSB first
//   FIN      | result registered, Listo high for this cycle only
module restador_serial #(
   parameter int ANCHO = 8
) (
   input  logic             Reloj,
   input  logic             Reset,
   input  logic             Inicio,
   input  logic [ANCHO-1:0] A,
   input  logic [ANCHO-1:0] B,
   output logic             Ocupado,
   output logic             Listo,
   output logic [ANCHO-1:0] Resta,
`ifdef RESTADOR_SERIAL_DESBORDE_EN
   output logic             PrestamoSalida,
   output logic             Desborde
`else
   output logic             PrestamoSalida
`endif
);

   localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,
      RESTANDO = 2'd1,
      FIN      = 2'd2
   } estado_t;

   estado_t estado, estado_sig;

   logic [ANCHO-1:0] sh_x;
   logic [ANCHO-1:0] sh_y;
   logic [ANCHO-1:0] sh_res;
   logic             prestamo;
   logic [CW-1:0]    cuenta;

   logic             r_bit;
   logic             prestamo_bit;
   logic [ANCHO-1:0] res_sig;
   logic             ultimo;

   Restador_Completo u_restador (
      .X             (sh_x[0]),
      .Y             (sh_y[0]),
      .CarrieNEntrada(prestamo),
      .R             (r_bit),
      .CarrieNSalida (prestamo_bit)
   );

   // The cell output enters at the MSB; after ANCHO shifts bit 0 of the
   // result has reached bit 0 of the register.
   assign res_sig = {r_bit, sh_res[ANCHO-1:1]};
   assign ultimo  = (cuenta == ULTIMO);

   always_ff @(posedge Reloj or posedge Reset) begin
      if (Reset) begin
         estado <= REPOSO;
      end else begin
         estado <= estado_sig;
      end
   end

   always_comb begin
      estado_sig = estado;
      Ocupado    = 1'b0;
      Listo      = 1'b0;
      case (estado)
         REPOSO: begin
            if (Inicio) begin
               estado_sig = RESTANDO;
            end
         end
         RESTANDO: begin
            Ocupado = 1'b1;
            if (ultimo) begin
               estado_sig = FIN;
            end
         end
         FIN: begin
            Listo      = 1'b1;
            estado_sig = REPOSO;
         end
         default: begin
            estado_sig = REPOSO;
         end
      endcase
   end

   always_ff @(posedge Reloj or posedge Reset) begin
      if (Reset) begin
         sh_x           <= '0;
         sh_y           <= '0;
         sh_res         <= '0;
         prestamo       <= 1'b0;
         cuenta         <= '0;
         Resta          <= '0;
         PrestamoSalida <= 1'b0;
      end else begin
         case (estado)
            REPOSO: begin
               if (Inicio) begin
                  sh_x     <= A;
                  sh_y     <= B;
                  sh_res   <= '0;
                  prestamo <= 1'b0;
                  cuenta   <= '0;
               end
            end
            RESTANDO: begin
               sh_x     <= {1'b0, sh_x[ANCHO-1:1]};
               sh_y     <= {1'b0, sh_y[ANCHO-1:1]};
               sh_res   <= res_sig;
               prestamo <= prestamo_bit;
               // Counter saturates at ANCHO-1: the exit edge does not wrap it.
               if (ultimo) begin
                  Resta          <= res_sig;
                  PrestamoSalida <= prestamo_bit;
               end else begin
                  cuenta <= cuenta + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef RESTADOR_SERIAL_DESBORDE_EN
   // Operand sign bits are shifted out during the run, so keep a copy.
   logic [1:0] msb_ab;

   always_ff @(posedge Reloj or posedge Reset) begin
      if (Reset) begin
         msb_ab   <= 2'b00;
         Desborde <= 1'b0;
      end else begin
         if (estado == REPOSO && Inicio) begin
            msb_ab <= {A[ANCHO-1], B[ANCHO-1]};
         end
         if (estado == RESTANDO && ultimo) begin
            // r_bit is the result MSB on the exit edge.
            Desborde <= (msb_ab[1] != msb_ab[0]) && (r_bit != msb_ab[1]);
         end
      end
   end
`endif

endmodule
